// File: rtl/hbf_decim_scheduler.sv
// hbf_decim_scheduler
//   Sequencer for a cascade of NUM_STAGES half-band decimate-by-2 filters that
//   share a single 18x18 multiplier and accumulator. Input samples arrive on a
//   valid/ready handshake. A phase counter decides how far down the cascade
//   each accepted sample propagates. Each scheduled stage then runs four states
//   (OUTER, INNER, CENTER, WRITE) that steer the tap select and the accumulator.
//
// Parameters
//   NUM_STAGES  number of cascaded half-band decimators (1..4)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   input sample present
//   in_ready   scheduler idle; sample accepted when in_valid && in_ready
//   shift_en   bit k: shift the stage-k delay line this cycle
//   stage_sel  stage currently owning the multiplier
//   tap_sel    0 outer pair, 1 inner pair, 2 centre tap, 3 unused
//   acc_clr    load accumulator with this cycle's product (no add)
//   acc_en     accumulator update enable
//   out_valid  one-cycle pulse: final-stage result valid at the accumulator
//   phase      decimation phase counter
//   overrun    sticky drop flag       (only with HBF_SCHED_OVERRUN_EN)
//   ovr_clr    clears overrun         (only with HBF_SCHED_OVERRUN_EN)
//
// Configuration macro
//   HBF_SCHED_OVERRUN_EN  adds the overrun/ovr_clr ports for non-stallable sources.

module hbf_decim_scheduler #(
  parameter int NUM_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_STAGES-1:0] shift_en,
  output logic [1:0]            stage_sel,
  output logic [1:0]            tap_sel,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  out_valid,
  output logic [NUM_STAGES-1:0] phase
`ifdef HBF_SCHED_OVERRUN_EN
  ,
  output logic                  overrun,
  input  logic                  ovr_clr
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OUTER,
    ST_INNER,
    ST_CENTER,
    ST_WRITE
  } state_t;

  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

  state_t                state;
  state_t                state_next;
  logic [1:0]            stage;
  logic [1:0]            stage_next;
  logic                  accept;
  logic [NUM_STAGES-1:0] prev_phase;
  logic                  run;

  // While a sequence is running, phase has already advanced past the accepted
  // sample, so the phase value that decided the schedule is phase-1.
  assign prev_phase = phase - NUM_STAGES'(1);

  // Next-state and control decode. Every output is forced low while reset is
  // held, so an aborted sequence never emits a stray strobe.
  always_comb begin
    state_next = state;
    stage_next = stage;
    in_ready   = 1'b0;
    shift_en   = '0;
    stage_sel  = 2'd0;
    tap_sel    = 2'd0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    run        = prev_phase[0];

    if (reset) begin
      case (state)
        ST_IDLE: begin
          in_ready    = 1'b1;
          accept      = in_valid;
          shift_en[0] = in_valid;
          stage_next  = 2'd0;
          // Stage 0 fires on every second input (phase bit 0 set).
          if (in_valid && phase[0]) begin
            state_next = ST_OUTER;
          end
        end
        ST_OUTER: begin
          stage_sel  = stage;
          tap_sel    = 2'd0;
          acc_clr    = 1'b1;
          acc_en     = 1'b1;
          state_next = ST_INNER;
        end
        ST_INNER: begin
          stage_sel  = stage;
          tap_sel    = 2'd1;
          acc_en     = 1'b1;
          state_next = ST_CENTER;
        end
        ST_CENTER: begin
          stage_sel  = stage;
          tap_sel    = 2'd2;
          acc_en     = 1'b1;
          state_next = ST_WRITE;
        end
        ST_WRITE: begin
          stage_sel  = stage;
          state_next = ST_IDLE;
          stage_next = 2'd0;
          if (stage == LAST_STAGE) begin
            out_valid = 1'b1;
          end else begin
            // The result of stage k feeds stage k+1's delay line; stage k+1
            // then runs only if all pre-increment phase bits 0..k+1 were set.
            for (int k = 0; k < NUM_STAGES - 1; k++) begin
              run = run & prev_phase[k+1];
              if (stage == 2'(k)) begin
                shift_en[k+1] = 1'b1;
                if (run) begin
                  state_next = ST_OUTER;
                  stage_next = 2'(k + 1);
                end
              end
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          stage_next = 2'd0;
        end
      endcase
    end
  end

  // State, stage index and phase counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      stage <= 2'd0;
      phase <= '0;
    end else begin
      state <= state_next;
      stage <= stage_next;
      if (accept) begin
        phase <= phase + NUM_STAGES'(1);
      end
    end
  end

`ifdef HBF_SCHED_OVERRUN_EN
  // Sticky drop flag: a sample offered while busy is lost for a source that
  // cannot stall. Setting takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_hbf_decim_scheduler.sv
// tb_hbf_decim_scheduler
//   Self-checking bench for hbf_decim_scheduler with NUM_STAGES=2.
//   Expected out_valid cycles go into a scoreboard queue when a sample is
//   accepted and are popped when the DUT pulses out_valid.

module tb_hbf_decim_scheduler;

  localparam int N  = 2;
  localparam int VW = N + 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] shift_en;
  logic [1:0]   stage_sel;
  logic [1:0]   tap_sel;
  logic         acc_clr;
  logic         acc_en;
  logic         out_valid;
  logic [N-1:0] phase;
`ifdef HBF_SCHED_OVERRUN_EN
  logic         overrun;
  logic         ovr_clr;
`endif

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int mphase   = 0;
  int ready_at = 0;
  int sb[$];

  hbf_decim_scheduler #(.NUM_STAGES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .stage_sel (stage_sel),
    .tap_sel   (tap_sel),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .phase     (phase)
`ifdef HBF_SCHED_OVERRUN_EN
    ,
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
`endif
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [VW-1:0] obs();
    return {in_ready, shift_en, acc_clr, acc_en, tap_sel, stage_sel, out_valid};
  endfunction

  // Number of stages scheduled by an accept at phase p (trailing ones).
  function automatic int nsched(int p);
    int  n;
    logic r;
    n = 0;
    r = 1'b1;
    for (int k = 0; k < N; k++) begin
      r = r & p[k];
      if (r) n = k + 1;
    end
    return n;
  endfunction

  // Expected control vector i cycles after an accept that schedules n stages.
  function automatic logic [VW-1:0] exp_vec(int i, int n);
    logic         r;
    logic [N-1:0] sh;
    logic         clr;
    logic         en;
    logic         ov;
    logic [1:0]   tap;
    logic [1:0]   st;
    int           j;
    int           s;
    r = 1'b0; sh = '0; clr = 1'b0; en = 1'b0; ov = 1'b0; tap = 2'd0; st = 2'd0;
    if (i <= 4 * n) begin
      j  = (i - 1) / 4;
      s  = (i - 1) % 4;
      st = 2'(j);
      case (s)
        0:       begin clr = 1'b1; en = 1'b1; tap = 2'd0; end
        1:       begin en = 1'b1; tap = 2'd1; end
        2:       begin en = 1'b1; tap = 2'd2; end
        default: begin
          if (j == N - 1) ov = 1'b1;
          else sh[j+1] = 1'b1;
        end
      endcase
    end else begin
      r = 1'b1;
    end
    return {r, sh, clr, en, tap, st, ov};
  endfunction

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
`ifdef HBF_SCHED_OVERRUN_EN
    ovr_clr  = 1'b0;
`endif
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      n_checks++;
      if ({obs(), phase} !== '0)
        $display("[TB] FAIL reset_outputs: got ctl=%b phase=%b, want all zero", obs(), phase);
      else n_pass++;
    end
    tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("[TB] FAIL reset_release_ready: got %b want 1", in_ready);
    else n_pass++;
    mphase   = 0;
    ready_at = 0;
  endtask

  task automatic test_idle_accept();
    tick();
    in_valid = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, shift_en} !== {1'b1, N'(1)})
      $display("[TB] FAIL idle_accept_shift: got ready=%b shift_en=%b want 1/01", in_ready, shift_en);
    else n_pass++;
    mphase = (mphase + 1) % (1 << N);
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({phase, obs()} !== {N'(mphase), exp_vec(1, 0)})
      $display("[TB] FAIL idle_accept_after: got phase=%b ctl=%b want phase=%0d ctl=%b",
               phase, obs(), mphase, exp_vec(1, 0));
    else n_pass++;
  endtask

  task automatic test_stage0_only();
    int n;
    tick();
    in_valid = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, shift_en} !== {1'b1, N'(1)})
      $display("[TB] FAIL stage0_accept: got ready=%b shift_en=%b want 1/01", in_ready, shift_en);
    else n_pass++;
    n      = nsched(mphase);
    mphase = (mphase + 1) % (1 << N);
    for (int i = 1; i <= 5; i++) begin
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (obs() !== exp_vec(i, n))
        $display("[TB] FAIL stage0_seq T+%0d: got ctl=%b want %b", i, obs(), exp_vec(i, n));
      else n_pass++;
    end
  endtask

  task automatic test_full_cascade();
    int n;
    // Phase-2 accept schedules nothing and moves phase to 3.
    tick();
    in_valid = 1'b1;
    #1;
    mphase = (mphase + 1) % (1 << N);
    tick();
    in_valid = 1'b1;
    #1;
    n_checks++;
    if ({phase, in_ready} !== {N'(mphase), 1'b1})
      $display("[TB] FAIL cascade_setup: got phase=%b ready=%b want %0d/1", phase, in_ready, mphase);
    else n_pass++;
    n = nsched(mphase);
    if (n == N) sb.push_back(cyc + 4 * N);
    mphase = (mphase + 1) % (1 << N);
    for (int i = 1; i <= 4 * N + 1; i++) begin
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (obs() !== exp_vec(i, n))
        $display("[TB] FAIL cascade_seq T+%0d: got ctl=%b want %b", i, obs(), exp_vec(i, n));
      else n_pass++;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0 || sb[0] != cyc)
          $display("[TB] FAIL cascade_out_time: got cycle %0d want %0d", cyc,
                   (sb.size() == 0) ? -1 : sb[0]);
        else n_pass++;
        if (sb.size() > 0) void'(sb.pop_front());
      end
    end
    n_checks++;
    if ({32'(sb.size()), phase} !== {32'd0, N'(mphase)})
      $display("[TB] FAIL cascade_end: got pending=%0d phase=%b want 0/%0d", sb.size(), phase, mphase);
    else n_pass++;
  endtask

  task automatic test_streaming();
    int  n;
    int  n_acc;
    int  n_out;
    int  exp_out;
    logic er;
    n_acc    = 0;
    n_out    = 0;
    exp_out  = 0;
    ready_at = cyc + 1;
    for (int c = 0; c < 80 + 40; c++) begin
      tick();
      in_valid = (c < 80);
      #1;
      if (c < 80) begin
        er = (cyc >= ready_at);
        n_checks++;
        if ({in_ready, shift_en[0]} !== {er, er})
          $display("[TB] FAIL stream_ready cycle %0d: got ready=%b shift0=%b want %b",
                   cyc, in_ready, shift_en[0], er);
        else n_pass++;
        if (er) begin
          n = nsched(mphase);
          if (n == N) begin
            sb.push_back(cyc + 4 * N);
            exp_out++;
          end
          ready_at = cyc + 1 + 4 * n;
          mphase   = (mphase + 1) % (1 << N);
          n_acc++;
        end
      end
      if (out_valid === 1'b1) begin
        n_out++;
        n_checks++;
        if (sb.size() == 0 || sb[0] != cyc)
          $display("[TB] FAIL stream_out_time: got cycle %0d want %0d", cyc,
                   (sb.size() == 0) ? -1 : sb[0]);
        else n_pass++;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (c >= 80 && cyc >= ready_at && sb.size() == 0) break;
    end
    n_checks++;
    if (sb.size() != 0 || n_out != exp_out)
      $display("[TB] FAIL stream_drain: got outs=%0d pending=%0d want outs=%0d pending=0",
               n_out, sb.size(), exp_out);
    else n_pass++;
    n_checks++;
    if (n_out * 4 != n_acc || n_acc == 0)
      $display("[TB] FAIL stream_ratio: got %0d outs for %0d accepts, want 1 per 4", n_out, n_acc);
    else n_pass++;
    n_checks++;
    if (phase !== N'(mphase))
      $display("[TB] FAIL stream_phase: got %b want %0d", phase, mphase);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int n;
    for (int c = 0; c < 30 && mphase != 3; c++) begin
      tick();
      if (cyc >= ready_at) begin
        in_valid = 1'b1;
        n        = nsched(mphase);
        ready_at = cyc + 1 + 4 * n;
        mphase   = (mphase + 1) % (1 << N);
      end else begin
        in_valid = 1'b0;
      end
      #1;
    end
    // Wait out any remaining busy time, then accept at phase 3.
    for (int c = 0; c < 30 && cyc + 1 < ready_at; c++) begin
      tick();
      in_valid = 1'b0;
      #1;
    end
    tick();
    in_valid = 1'b1;
    #1;
    n_checks++;
    if ({phase, in_ready} !== {2'd3, 1'b1})
      $display("[TB] FAIL abort_setup: got phase=%b ready=%b want 3/1", phase, in_ready);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (obs() !== exp_vec(i, N))
        $display("[TB] FAIL abort_pre T+%0d: got ctl=%b want %b", i, obs(), exp_vec(i, N));
      else n_pass++;
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== '0)
      $display("[TB] FAIL abort_during_reset: got ctl=%b want 0", obs());
    else n_pass++;
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, phase, acc_en} !== {1'b1, N'(0), 1'b0})
      $display("[TB] FAIL abort_release: got ready=%b phase=%b acc_en=%b want 1/0/0",
               in_ready, phase, acc_en);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      n_checks++;
      if ({out_valid, shift_en, acc_en} !== '0)
        $display("[TB] FAIL abort_quiet +%0d: got out_valid=%b shift_en=%b acc_en=%b want 0",
                 i, out_valid, shift_en, acc_en);
      else n_pass++;
    end
    mphase   = 0;
    ready_at = 0;
  endtask

`ifdef HBF_SCHED_OVERRUN_EN
  task automatic test_overrun();
    tick();
    in_valid = 1'b0;
    ovr_clr  = 1'b1;
    #1;
    tick();
    ovr_clr = 1'b0;
    #1;
    n_checks++;
    if (overrun !== 1'b0)
      $display("[TB] FAIL ovr_initial_clear: got %b want 0", overrun);
    else n_pass++;
    tick();
    in_valid = 1'b1;
    #1;
    tick();
    #1;
    tick();
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (overrun !== 1'b1)
      $display("[TB] FAIL ovr_set: got %b want 1", overrun);
    else n_pass++;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    #1;
    n_checks++;
    if (overrun !== 1'b0)
      $display("[TB] FAIL ovr_clear: got %b want 0", overrun);
    else n_pass++;
    in_valid = 1'b1;
    ovr_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    ovr_clr  = 1'b0;
    #1;
    n_checks++;
    if (overrun !== 1'b1)
      $display("[TB] FAIL ovr_set_wins: got %b want 1", overrun);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      tick();
      #1;
    end
    mphase   = 2;
    ready_at = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_accept();
    test_stage0_only();
    test_full_cascade();
    test_streaming();
    test_reset_abort();
`ifdef HBF_SCHED_OVERRUN_EN
    test_overrun();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
